// File: rtl/palette_ram.sv
// Palette lookup RAM with one-cycle registered colour output and optional frame-based fade.
// Define PALETTE_FADE_EN to build in the brightness FSM and per-channel scaling multiplier.
module palette_ram #(
  parameter int NUM_ENTRIES = 16,
  parameter int COLOR_BITS  = 4,
  localparam int IW         = $clog2(NUM_ENTRIES)
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    we,
  input  logic [IW-1:0]           waddr,
  input  logic [3*COLOR_BITS-1:0] wdata,
  input  logic [IW-1:0]           index,
  input  logic                    pix_valid_in,
  input  logic                    fade_out_start,
  input  logic                    fade_in_start,
  input  logic                    frame_tick,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    pix_valid_out,
  output logic                    fade_busy,
  output logic                    fade_done
);

  localparam int CB = COLOR_BITS;
  localparam int DW = 3 * COLOR_BITS;

  logic [DW-1:0] r_pal [NUM_ENTRIES];
  logic [DW-1:0] w_entry_p0;
  logic [DW-1:0] w_rgb_p0;
  logic [DW-1:0] r_rgb_p1;
  logic          r_vld_p1;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_pal[i] <= '0;
    end else if (we) begin
      r_pal[waddr] <= wdata;
    end
  end

  // A write landing on the entry being looked up is forwarded so the pixel sees the new colour.
  assign w_entry_p0 = (we && (waddr == index)) ? wdata : r_pal[index];

`ifdef PALETTE_FADE_EN
  localparam int BW = COLOR_BITS + 1;
  localparam int PW = 2 * COLOR_BITS;
  localparam logic [BW-1:0] B_FULL = {1'b1, {COLOR_BITS{1'b0}}};
  localparam logic [BW-1:0] B_ONE  = BW'(1);

  typedef enum logic [1:0] {S_IDLE, S_FADE_OUT, S_BLACK, S_FADE_IN} state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_bright, w_bright_nxt;

  function automatic logic [CB-1:0] scale(input logic [CB-1:0] c, input logic [BW-1:0] b);
    logic [PW-1:0] prod;
    prod = PW'(c) * PW'(b);
    return prod[PW-1:CB];
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= S_IDLE;
      r_bright <= B_FULL;
    end else begin
      r_state  <= w_state_nxt;
      r_bright <= w_bright_nxt;
    end
  end

  // Start commands take priority over frame_tick, so brightness never steps on a transition edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_bright_nxt = r_bright;
    case (r_state)
      S_IDLE: begin
        w_bright_nxt = B_FULL;
        if (fade_out_start) w_state_nxt = S_FADE_OUT;
      end
      S_FADE_OUT: begin
        if (fade_in_start && !fade_out_start) begin
          w_state_nxt = S_FADE_IN;
        end else if (frame_tick) begin
          if (r_bright <= B_ONE) begin
            w_bright_nxt = '0;
            w_state_nxt  = S_BLACK;
          end else begin
            w_bright_nxt = r_bright - B_ONE;
          end
        end
      end
      S_BLACK: begin
        w_bright_nxt = '0;
        if (fade_in_start) w_state_nxt = S_FADE_IN;
      end
      S_FADE_IN: begin
        if (fade_out_start) begin
          w_state_nxt = S_FADE_OUT;
        end else if (frame_tick) begin
          if (r_bright >= (B_FULL - B_ONE)) begin
            w_bright_nxt = B_FULL;
            w_state_nxt  = S_IDLE;
          end else begin
            w_bright_nxt = r_bright + B_ONE;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_bright_nxt = B_FULL;
      end
    endcase
  end

  assign w_rgb_p0  = {scale(w_entry_p0[DW-1:2*CB], r_bright),
                      scale(w_entry_p0[2*CB-1:CB], r_bright),
                      scale(w_entry_p0[CB-1:0],    r_bright)};
  assign fade_busy = (r_state == S_FADE_OUT) || (r_state == S_FADE_IN);
  assign fade_done = (r_state == S_BLACK);
`else
  logic w_unused;
  assign w_unused  = &{1'b0, fade_out_start, fade_in_start, frame_tick};
  assign w_rgb_p0  = w_entry_p0;
  assign fade_busy = 1'b0;
  assign fade_done = 1'b0;
`endif

  // ---- stage p0 -> p1: registered colour, held while no valid pixel ----
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rgb_p1 <= '0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_vld_p1 <= pix_valid_in;
      if (pix_valid_in) r_rgb_p1 <= w_rgb_p0;
    end
  end

  assign red           = r_rgb_p1[DW-1:2*CB];
  assign green         = r_rgb_p1[2*CB-1:CB];
  assign blue          = r_rgb_p1[CB-1:0];
  assign pix_valid_out = r_vld_p1;

endmodule

// File: tb/tb_palette_ram.sv
// Directed bench for palette_ram: lookup, bypass, hold, reset, and the fade sequence when
// PALETTE_FADE_EN is defined (otherwise checks that fade inputs have no effect).
module tb_palette_ram;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        we;
  logic [3:0]  waddr;
  logic [11:0] wdata;
  logic [3:0]  index;
  logic        pix_valid_in;
  logic        fade_out_start;
  logic        fade_in_start;
  logic        frame_tick;
  logic [3:0]  red, green, blue;
  logic        pix_valid_out;
  logic        fade_busy;
  logic        fade_done;

  int vectors = 0;
  int miscompares = 0;

  palette_ram #(.NUM_ENTRIES(16), .COLOR_BITS(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .we(we), .waddr(waddr), .wdata(wdata),
    .index(index), .pix_valid_in(pix_valid_in), .fade_out_start(fade_out_start),
    .fade_in_start(fade_in_start), .frame_tick(frame_tick), .red(red), .green(green),
    .blue(blue), .pix_valid_out(pix_valid_out), .fade_busy(fade_busy), .fade_done(fade_done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [11:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] i);
    index = i; pix_valid_in = 1'b1;
    cyc();
    pix_valid_in = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  logic [11:0] rgb;
  assign rgb = {red, green, blue};

  initial begin
    logic [3:0] e;
    Reset_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; index = '0; pix_valid_in = 1'b0;
    fade_out_start = 1'b0; fade_in_start = 1'b0; frame_tick = 1'b0;
    #12;
    chk("reset_rgb", 32'(rgb), 32'h000);
    chk("reset_vld", 32'(pix_valid_out), 32'd0);
    chk("reset_busy", 32'(fade_busy), 32'd0);
    chk("reset_done", 32'(fade_done), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    cyc();

    write_entry(4'd3, 12'hF5C);
    lookup(4'd3);
    chk("lookup3_rgb", 32'(rgb), 32'hF5C);
    chk("lookup3_vld", 32'(pix_valid_out), 32'd1);
    index = 4'd0;
    cyc();
    chk("hold_vld", 32'(pix_valid_out), 32'd0);
    chk("hold_rgb", 32'(rgb), 32'hF5C);

    we = 1'b1; waddr = 4'd7; wdata = 12'h1FE; index = 4'd7; pix_valid_in = 1'b1;
    cyc();
    we = 1'b0; pix_valid_in = 1'b0;
    chk("bypass7", 32'(rgb), 32'h1FE);
    cyc();
    lookup(4'd7);
    chk("reread7", 32'(rgb), 32'h1FE);

    we = 1'b1; waddr = 4'd3; wdata = 12'h123; index = 4'd3; pix_valid_in = 1'b1;
    cyc();
    we = 1'b0; pix_valid_in = 1'b0;
    chk("bypass_overwrite3", 32'(rgb), 32'h123);
    we = 1'b1; waddr = 4'd5; wdata = 12'hABC; index = 4'd3; pix_valid_in = 1'b1;
    cyc();
    we = 1'b0; pix_valid_in = 1'b0;
    chk("no_bypass_other", 32'(rgb), 32'h123);
    lookup(4'd5);
    chk("read5", 32'(rgb), 32'hABC);
    lookup(4'd9);
    chk("unwritten9", 32'(rgb), 32'h000);

    write_entry(4'd0, 12'hFFF);
    lookup(4'd0);
    chk("full_bright", 32'(rgb), 32'hFFF);

`ifdef PALETTE_FADE_EN
    fade_in_start = 1'b1; cyc(); fade_in_start = 1'b0;
    chk("idle_ignore_in", 32'(fade_busy), 32'd0);

    fade_out_start = 1'b1; cyc(); fade_out_start = 1'b0;
    chk("fo_busy_start", 32'(fade_busy), 32'd1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("fo_done", 32'(fade_done), (i == 16) ? 32'd1 : 32'd0);
      chk("fo_busy", 32'(fade_busy), (i == 16) ? 32'd0 : 32'd1);
      lookup(4'd0);
      e = 4'((15 * (16 - i)) >> 4);
      chk("fo_rgb", 32'(rgb), 32'({e, e, e}));
      if (i == 1) chk("fo_first_tick", 32'(rgb), 32'hEEE);
    end

    fade_out_start = 1'b1; cyc(); fade_out_start = 1'b0;
    chk("black_ignore_out", 32'(fade_done), 32'd1);

    fade_in_start = 1'b1; cyc(); fade_in_start = 1'b0;
    chk("fi_busy_start", 32'(fade_busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("fi_busy", 32'(fade_busy), 32'd1);
    end
    lookup(4'd0);
    chk("fi_half", 32'(rgb), 32'h777);
    fade_out_start = 1'b1; cyc(); fade_out_start = 1'b0;
    chk("rev_busy", 32'(fade_busy), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("rev_busy_tick", 32'(fade_busy), (i == 8) ? 32'd0 : 32'd1);
    end
    chk("rev_black", 32'(fade_done), 32'd1);
    lookup(4'd0);
    chk("rev_black_rgb", 32'(rgb), 32'h000);

    fade_in_start = 1'b1; frame_tick = 1'b1; cyc(); fade_in_start = 1'b0; frame_tick = 1'b0;
    tick(); tick();
    lookup(4'd0);
    chk("start_no_step", 32'(rgb), 32'h111);

    fade_out_start = 1'b1; fade_in_start = 1'b1; cyc();
    fade_out_start = 1'b0; fade_in_start = 1'b0;
    tick(); tick();
    chk("out_wins_done", 32'(fade_done), 32'd1);

    fade_in_start = 1'b1; cyc(); fade_in_start = 1'b0;
    tick(); tick(); tick();
    lookup(4'd0);
    chk("fi_b3", 32'(rgb), 32'h222);
    chk("mid_fade_busy", 32'(fade_busy), 32'd1);
`else
    fade_out_start = 1'b1; cyc(); fade_out_start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    lookup(4'd0);
    chk("nofade_rgb", 32'(rgb), 32'hFFF);
    chk("nofade_done", 32'(fade_done), 32'd0);
    chk("nofade_busy", 32'(fade_busy), 32'd0);
    lookup(4'd0);
`endif

    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", 32'(rgb), 32'h000);
    chk("async_rst_vld", 32'(pix_valid_out), 32'd0);
    chk("async_rst_busy", 32'(fade_busy), 32'd0);
    chk("async_rst_done", 32'(fade_done), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;
    cyc();
    tick();
    chk("post_rst_busy", 32'(fade_busy), 32'd0);
    lookup(4'd0);
    chk("post_rst_entry0", 32'(rgb), 32'h000);
    write_entry(4'd0, 12'hFFF);
    lookup(4'd0);
    chk("post_rst_idle_full", 32'(rgb), 32'hFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/palette_ram.md
PALETTE_RAM -- requirements
Module: palette_ram

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 16: number of palette entries; power of two, minimum 2.
REQ-002 The block SHALL have parameter COLOR_BITS, default 4: bits per colour channel.
REQ-003 The block SHALL derive IW = clog2(NUM_ENTRIES) as the index width.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port we, input, 1 bit: palette write enable.
REQ-007 The block SHALL have port waddr, input, IW bits: write entry.
REQ-008 The block SHALL have port wdata, input, 3*COLOR_BITS bits, packed {R,G,B}: write colour.
REQ-009 The block SHALL have port index, input, IW bits: pixel lookup index.
REQ-010 The block SHALL have port pix_valid_in, input, 1 bit: index is a valid pixel.
REQ-011 The block SHALL have ports red, green, blue, outputs, COLOR_BITS bits each: registered colour.
REQ-012 The block SHALL have port pix_valid_out, output, 1 bit: red/green/blue valid.
REQ-013 The block SHALL have ports fade_out_start and fade_in_start, inputs, 1 bit each: single-cycle fade commands.
REQ-014 The block SHALL have port frame_tick, input, 1 bit: single-cycle once-per-frame strobe.
REQ-015 The block SHALL have port fade_busy, output, 1 bit: high while a fade is in progress.
REQ-016 The block SHALL have port fade_done, output, 1 bit: high while held at black.

Function
REQ-017 The block SHALL hold NUM_ENTRIES x 3*COLOR_BITS palette registers; when we=1, wdata is written to entry waddr at the clock edge.
REQ-018 Lookup latency SHALL be exactly 1 cycle: the colour for index at edge N appears on red/green/blue after edge N, and pix_valid_out equals pix_valid_in delayed 1 cycle.
REQ-019 red/green/blue SHALL update only when pix_valid_in=1; otherwise they hold their previous value.
REQ-020 When we=1, pix_valid_in=1 and waddr==index in the same cycle, the output SHALL be wdata (write-through bypass).
REQ-021 Output colour SHALL be c_out = (c * B) >> COLOR_BITS for each channel, with c the entry value and brightness B (COLOR_BITS+1 bits, 0..2^COLOR_BITS); the product is computed at full width with no rounding.
REQ-022 When B = 2^COLOR_BITS, the output SHALL equal the entry value exactly.
REQ-023 The fade FSM SHALL have states IDLE, FADE_OUT, BLACK and FADE_IN.
REQ-024 In IDLE: B = 2^COLOR_BITS, fade_busy=0, fade_done=0; fade_out_start moves to FADE_OUT.
REQ-025 In FADE_OUT: B decrements by 1 per frame_tick; when B reaches 0 the FSM enters BLACK on the same edge.
REQ-026 In BLACK: B = 0 and fade_done=1; fade_in_start moves to FADE_IN.
REQ-027 In FADE_IN: B increments by 1 per frame_tick; when B reaches 2^COLOR_BITS the FSM enters IDLE.
REQ-028 fade_busy SHALL be 1 in FADE_OUT and FADE_IN only.
REQ-029 fade_out_start in FADE_IN SHALL reverse to FADE_OUT from the current B; fade_in_start in FADE_OUT SHALL reverse to FADE_IN from the current B.
REQ-030 If fade_out_start and fade_in_start are both asserted, fade_out_start SHALL win.
REQ-031 A start command and frame_tick in the same cycle SHALL apply the state change only; B does not step on that edge.
REQ-032 fade_out_start in BLACK or FADE_OUT, and fade_in_start in IDLE or FADE_IN, SHALL be ignored.
REQ-033 B SHALL never wrap below 0 or above 2^COLOR_BITS.
REQ-034 Palette writes SHALL be accepted in every fade state.

Reset
REQ-035 While Reset_n=0, asynchronously: all entries = 0, red/green/blue = 0, pix_valid_out = 0, FSM = IDLE, B = 2^COLOR_BITS, fade_busy = 0, fade_done = 0.
REQ-036 Reset asserted mid-fade SHALL abort the fade to IDLE; after release the first valid lookup SHALL return 0 until the entry is written.

Configuration
REQ-037 With macro PALETTE_FADE_EN defined, the fade FSM and multiplier SHALL be compiled in as specified.
REQ-038 Without PALETTE_FADE_EN: output = entry value, fade inputs are ignored, fade_busy = 0 and fade_done = 0, and no multiplier or FSM logic is present.

Verification
REQ-039 Defaults: write entry 3 = 0xF5C; index=3 with valid for 1 cycle -> next cycle red=F, green=5, blue=C, pix_valid_out=1.
REQ-040 Same-cycle write entry 7 = 0x1FE with index=7 -> next-cycle output 0x1FE; index=7 two cycles later still reads 0x1FE.
REQ-041 Entry 0 = 0xFFF; fade_out_start, then 16 frame_ticks -> B = 15..0 with output 0xEEE after the first tick and 0x000 after the 16th; fade_done=1 on the 16th tick edge.
REQ-042 From BLACK: fade_in_start, 8 ticks, then fade_out_start, 8 ticks -> BLACK; fade_busy=1 throughout the fade.
REQ-043 Assert Reset_n=0 mid-fade, asynchronously without a clock edge -> red/green/blue = 0, fade_busy = 0, and FSM in IDLE.
REQ-044 Build without PALETTE_FADE_EN; pulse fade_out_start plus 20 frame_ticks -> output unchanged at 0xFFF and fade_done = 0.
